mem_array_arbiter: RTL



---
 rtl/mem_array_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_array_arbiter.sv
// mem_array_arbiter: round-robin front end sharing one DEPTH x DATA_W register
// array between NUM_REQ requesters, one granted operation per cycle.
// Optional feature macro: MEM_ARB_SEARCH_EN enables the sequential
// "value inside array" search (op 10); without it op 10 is rejected like op 11.
module mem_array_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [2*NUM_REQ-1:0]        req_op,
    input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
    input  logic [DATA_W*NUM_REQ-1:0]   req_wdata,
    output logic                        rsp_valid,
    output logic [1:0]                  rsp_id,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_hit,
    output logic [ADDR_W-1:0]           rsp_idx,
    output logic                        rsp_err,
    output logic                        busy
);

    localparam int unsigned IDX_W = 2;
    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
`ifdef MEM_ARB_SEARCH_EN
    localparam logic [1:0] OP_SR = 2'b10;
`endif

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  prio_ptr;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_found;
    logic              idle_c;
    logic              hs_c;
    int unsigned       cand;
    logic [1:0]        sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              rsp_valid_d;
    logic [1:0]        rsp_id_d;
    logic [DATA_W-1:0] rsp_data_d;
    logic              rsp_err_d;

`ifdef MEM_ARB_SEARCH_EN
    typedef enum logic [0:0] {S_IDLE, S_SEARCH} state_t;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [1:0]        sid_q, sid_d;
    logic              rsp_hit_d;
    logic [ADDR_W-1:0] rsp_idx_d;

    assign idle_c = (state_q == S_IDLE);
    assign busy   = (state_q == S_SEARCH);
`else
    assign idle_c  = 1'b1;
    assign busy    = 1'b0;
    assign rsp_hit = 1'b0;
    assign rsp_idx = '0;
`endif

    // Round-robin pick: first asserted request at or after prio_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            cand = (32'(prio_ptr) + j) % NUM_REQ;
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    // One-hot grant, suppressed during reset and while a search owns the array.
    always_comb begin
        req_ready = '0;
        if (!rst && idle_c && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign hs_c      = !rst && idle_c && gnt_found;
    assign sel_op    = req_op[2*gnt_idx +: 2];
    assign sel_addr  = req_addr[ADDR_W*gnt_idx +: ADDR_W];
    assign sel_wdata = req_wdata[DATA_W*gnt_idx +: DATA_W];

    // Priority pointer moves past the requester just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_ptr <= '0;
        end else if (hs_c) begin
            prio_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Storage array; intentionally not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (hs_c && sel_op == OP_WR) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    // Next-state and response decode for granted ops and the search scan.
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
`ifdef MEM_ARB_SEARCH_EN
        rsp_hit_d   = rsp_hit;
        rsp_idx_d   = rsp_idx;
        state_d     = state_q;
        key_d       = key_q;
        k_d         = k_q;
        sid_d       = sid_q;
`endif
        if (hs_c) begin
            case (sel_op)
                OP_RD: begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = gnt_idx;
                    rsp_data_d  = mem[sel_addr];
                    rsp_err_d   = 1'b0;
`ifdef MEM_ARB_SEARCH_EN
                    rsp_hit_d   = 1'b0;
                    rsp_idx_d   = '0;
`endif
                end
                OP_WR: begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = gnt_idx;
                    rsp_data_d  = sel_wdata;
                    rsp_err_d   = 1'b0;
`ifdef MEM_ARB_SEARCH_EN
                    rsp_hit_d   = 1'b0;
                    rsp_idx_d   = '0;
`endif
                end
`ifdef MEM_ARB_SEARCH_EN
                OP_SR: begin
                    state_d = S_SEARCH;
                    key_d   = sel_wdata;
                    k_d     = '0;
                    sid_d   = gnt_idx;
                end
`endif
                default: begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = gnt_idx;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
`ifdef MEM_ARB_SEARCH_EN
                    rsp_hit_d   = 1'b0;
                    rsp_idx_d   = '0;
`endif
                end
            endcase
        end
`ifdef MEM_ARB_SEARCH_EN
        if (state_q == S_SEARCH) begin
            if (mem[k_q] == key_q) begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = sid_q;
                rsp_data_d  = mem[k_q];
                rsp_hit_d   = 1'b1;
                rsp_idx_d   = k_q;
                rsp_err_d   = 1'b0;
                state_d     = S_IDLE;
            end else if (k_q == ADDR_W'(DEPTH - 1)) begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = sid_q;
                rsp_data_d  = '0;
                rsp_hit_d   = 1'b0;
                rsp_idx_d   = '0;
                rsp_err_d   = 1'b0;
                state_d     = S_IDLE;
            end else begin
                k_d = k_q + 1'b1;
            end
        end
`endif
    end

    // State and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
`ifdef MEM_ARB_SEARCH_EN
            rsp_hit   <= 1'b0;
            rsp_idx   <= '0;
            state_q   <= S_IDLE;
            key_q     <= '0;
            k_q       <= '0;
            sid_q     <= '0;
`endif
        end else begin
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
`ifdef MEM_ARB_SEARCH_EN
            rsp_hit   <= rsp_hit_d;
            rsp_idx   <= rsp_idx_d;
            state_q   <= state_d;
            key_q     <= key_d;
            k_q       <= k_d;
            sid_q     <= sid_d;
`endif
        end
    end

endmodule
